// File: rtl/lcd_reader.sv
// lcd_reader: HD44780-style read-cycle engine.
// Performs a read (LCD_RW=1) of either the busy-flag/address byte (RS=0) or a
// DDRAM/CGRAM data byte (RS=1). In poll mode it re-reads the busy flag until
// it clears or POLL_MAX extra reads have been made.
//
// Ports:
//   iCLK      system clock
//   iRST      asynchronous reset, active-high
//   iRS       register select for the read, sampled at start
//   iPoll     busy-poll request, sampled at start, honoured only when iRS=0
//   iStart    rising edge launches a transaction (ignored while busy)
//   oDone     transaction complete, held until the next accepted start
//   oTimeout  poll ended with busy flag still set, valid with oDone
//   oBusy     block owns the LCD bus
//   oDATA     last byte sampled from the LCD
//   LCD_DATA  LCD data pins (input path from pad)
//   LCD_RW    1 during a transaction
//   LCD_EN    enable strobe
//   LCD_RS    latched register select
module lcd_reader #(
  parameter int unsigned CLK_Divide = 16,
  parameter int unsigned SETUP      = 2,
  parameter int unsigned HOLD       = 2,
  parameter int unsigned POLL_MAX   = 255
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iRS,
  input  logic       iPoll,
  input  logic       iStart,
  output logic       oDone,
  output logic       oTimeout,
  output logic       oBusy,
  output logic [7:0] oDATA,
  input  logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  typedef enum logic [2:0] {StIdle, StSetup, StEnHi, StHold, StCheck} state_e;

  localparam logic [7:0] SetupLast = 8'(SETUP - 1);
  localparam logic [7:0] EnLast    = 8'(CLK_Divide - 1);
  localparam logic [7:0] HoldLast  = 8'(HOLD - 1);
  localparam logic [7:0] PollMax   = 8'(POLL_MAX);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic       poll_q, poll_d;
  logic       start_prev_q;
  logic       done_q, done_d;
  logic       timeout_q, timeout_d;
  logic       busy_q, busy_d;
  logic [7:0] data_q, data_d;
  logic       rw_q, rw_d;
  logic       en_q, en_d;
  logic       rs_q, rs_d;
  logic       start_edge;

  assign start_edge = iStart & ~start_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poll_cnt_d = poll_cnt_q;
    poll_d     = poll_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    busy_d     = busy_q;
    data_d     = data_q;
    rw_d       = rw_q;
    en_d       = en_q;
    rs_d       = rs_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          poll_d     = iPoll & ~iRS;
          rs_d       = iRS;
          rw_d       = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          poll_cnt_d = 8'd0;
          cnt_d      = 8'd0;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = 8'd0;
          en_d    = 1'b1;
          state_d = StEnHi;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StEnHi: begin
        if (cnt_q == EnLast) begin
          // Sample on the same edge EN falls, so the pad is read while EN is still high.
          cnt_d   = 8'd0;
          en_d    = 1'b0;
          data_d  = LCD_DATA;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = 8'd0;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCheck: begin
        if (poll_q && data_q[7] && (poll_cnt_q < PollMax)) begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          state_d    = StSetup;
        end else begin
          timeout_d = poll_q & data_q[7];
          done_d    = 1'b1;
          busy_d    = 1'b0;
          rw_d      = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      poll_cnt_q   <= 8'd0;
      poll_q       <= 1'b0;
      start_prev_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      data_q       <= 8'h00;
      rw_q         <= 1'b0;
      en_q         <= 1'b0;
      rs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      poll_q       <= poll_d;
      start_prev_q <= iStart;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      data_q       <= data_d;
      rw_q         <= rw_d;
      en_q         <= en_d;
      rs_q         <= rs_d;
    end
  end

  assign oDone    = done_q;
  assign oTimeout = timeout_q;
  assign oBusy    = busy_q;
  assign oDATA    = data_q;
  assign LCD_RW   = rw_q;
  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;

endmodule
